branch_history_table_scheduler: RTL
===================================

Name: branch_history_table_scheduler

Overview:
- Owns a single-port, synchronous-read table of 2-bit saturating counters, indexed by PC.
- Arbitrates that table port between two users:
  - decode-stage prediction lookups;
  - EX-stage feedback updates, performed as read-modify-write.
- Buffers feedback in a small FIFO and runs the table initialisation sequence after reset and after flush.
- Sits between branch_controller and the table SRAM.

Parameters:
- ADDR_WIDTH, 32, PC width.
- INDEX_BITS, 6, table depth is 2**INDEX_BITS; index = pc[INDEX_BITS+1:2].
- FB_DEPTH, 4, feedback FIFO entries (power of 2, >=2).
- INIT_VALUE, 2'b01, counter value written at init (weakly not taken).

Ports:
- clk  in  1  clock. Only clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  clear FIFO, re-initialise table.
- i_req_valid  in  1  lookup request.
- i_req_pc  in  ADDR_WIDTH  lookup PC.
- o_req_ready  out  1  lookup accepted this cycle.
- o_pred_valid  out  1  prediction valid; one cycle after an accepted lookup.
- o_pred  out  1  mips_core_pkg::BranchOutcome.
- i_fb_valid  in  1  resolved branch.
- i_fb_pc  in  ADDR_WIDTH  resolved branch PC.
- i_fb_outcome  in  1  BranchOutcome.
- o_fb_drop  out  1  one-cycle pulse: feedback lost because the FIFO was full.
- o_init_busy  out  1  high in START/INIT.
- o_tbl_en  out  1  table port enable.
- o_tbl_we  out  1  table write.
- o_tbl_addr  out  INDEX_BITS  table address.
- o_tbl_wdata  out  2  write data.
- i_tbl_rdata  in  2  read data, valid the cycle after a read.

Behaviour:
- Reset (rst_n low, async):
  - state=START, FIFO empty, init index 0.
  - o_pred_valid=0, o_pred=NOT_TAKEN, o_fb_drop=0.
  - o_tbl_en=0, o_tbl_we=0, o_tbl_addr=0, o_tbl_wdata=0.
  - o_init_busy=1, o_req_ready=0.
- Table port outputs are combinational from state, FIFO head and request inputs.
- START: port idle, o_req_ready=0. Next cycle goes to INIT.
- INIT:
  - Each cycle writes INIT_VALUE at the init index, then increments the index.
  - After writing index 2**INDEX_BITS-1, goes to RUN; index wraps to 0.
  - o_req_ready=1. Lookups are answered next cycle with o_pred_valid=1, o_pred=NOT_TAKEN, without using the port.
  - Feedback is still enqueued.
- RUN: port grant per cycle, in priority order:
  1. WRITE phase of an in-flight RMW:
     - we=1, addr=held index;
     - wdata = rdata+1 saturating at 3 for TAKEN, rdata-1 saturating at 0 for NOT_TAKEN;
     - pop FIFO head this cycle.
  2. FIFO full: start RMW READ of the head.
  3. i_req_valid: lookup read, o_req_ready=1.
  4. FIFO non-empty: RMW READ of the head.
- o_req_ready=0 whenever the port goes to priorities 1, 2 or 4, or the state is not RUN/INIT. Decode must hold the request while not ready.
- RMW timing:
  - READ at cycle N, WRITE at N+1, always back to back.
  - Consecutive updates to the same index therefore see the prior write.
  - A lookup that races a still-queued update returns the stale counter. This is permitted.
- Prediction: o_pred_valid=1 at N+1 after an accepted lookup at N; o_pred = TAKEN iff i_tbl_rdata[1].
- Feedback enqueue:
  - Every cycle i_fb_valid=1, unless the FIFO is full and not popping that cycle.
  - In that case the entry is discarded and o_fb_drop=1 for that cycle.
  - Simultaneous push and pop on a full FIFO is accepted.
- i_flush (any state, synchronous):
  - Next state START, FIFO emptied, in-flight RMW abandoned (no write).
  - A pending prediction still completes; it is answered NOT_TAKEN.
  - Feedback arriving in the flush cycle is discarded without o_fb_drop.
- Reset asserted mid-RMW or mid-INIT: immediate return to reset values. No partial write is issued after reset asserts.

Test Plan (INDEX_BITS=2, FB_DEPTH=4):
- Release reset:
  - 1 START cycle, then 4 writes addr 0..3 with wdata 01, o_init_busy=1 for 5 cycles.
  - Lookup pc 0x10 during INIT -> next cycle o_pred_valid=1, o_pred=NOT_TAKEN, no port access.
- After INIT, feedback pc 0x4 TAKEN twice, no lookups:
  - READ addr1, WRITE addr1 wdata 10, READ addr1, WRITE addr1 wdata 11.
  - Lookup pc 0x4 then returns TAKEN.
- Saturation:
  - Counter at 11 plus TAKEN -> wdata 11.
  - Counter at 00 plus NOT_TAKEN -> wdata 00.
- Lookups every cycle with 4 feedbacks queued:
  - FIFO full forces READ/WRITE; o_req_ready=0 on those 2 cycles.
  - A 5th feedback in a full, non-popping cycle -> o_fb_drop=1, FIFO count stays 4.
- Flush during RMW WRITE-pending with 3 queued:
  - No write issued, FIFO empty, START then 4 init writes of 01.
  - A subsequent lookup of a previously trained index -> NOT_TAKEN.
- Assert rst_n low mid-INIT at index 2: all outputs return to reset values asynchronously, and the sequence restarts from index 0.

Source files
------------

// File: rtl/branch_history_table_scheduler.sv
// Branch history table scheduler: owns the single-port table of 2-bit
// saturating counters and shares its port between decode lookups and
// EX-stage feedback read-modify-write updates. Runs the table init sequence
// after reset and after flush.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   i_flush                            clear feedback FIFO, re-initialise table
//   i_req_valid/i_req_pc/o_req_ready   lookup request / accept
//   o_pred_valid/o_pred                prediction, one cycle after accept (1 = taken)
//   i_fb_valid/i_fb_pc/i_fb_outcome    resolved-branch feedback (1 = taken)
//   o_fb_drop                          feedback lost to a full FIFO
//   o_init_busy                        table initialisation in progress
//   o_tbl_en/we/addr/wdata, i_tbl_rdata  table SRAM port (read data next cycle)
module branch_history_table_scheduler #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned FB_DEPTH   = 4,
  parameter logic [1:0]  INIT_VALUE = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  output logic                  o_req_ready,
  output logic                  o_pred_valid,
  output logic                  o_pred,
  input  logic                  i_fb_valid,
  input  logic [ADDR_WIDTH-1:0] i_fb_pc,
  input  logic                  i_fb_outcome,
  output logic                  o_fb_drop,
  output logic                  o_init_busy,
  output logic                  o_tbl_en,
  output logic                  o_tbl_we,
  output logic [INDEX_BITS-1:0] o_tbl_addr,
  output logic [1:0]            o_tbl_wdata,
  input  logic [1:0]            i_tbl_rdata
);

  localparam int unsigned PTR_W = $clog2(FB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_START, ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  logic [INDEX_BITS-1:0] r_init_idx;
  logic [INDEX_BITS-1:0] r_fb_idx [FB_DEPTH];
  logic                  r_fb_taken [FB_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_rmw_wr;     // READ issued last cycle, WRITE due now
  logic                  r_pred_valid;
  logic                  r_pred_tbl;   // pending prediction comes from the table

  logic [INDEX_BITS-1:0] w_req_idx;
  logic [INDEX_BITS-1:0] w_fb_idx;
  logic [INDEX_BITS-1:0] w_head_idx;
  logic                  w_head_taken;
  logic                  w_full;
  logic                  w_empty;
  logic [1:0]            w_upd;
  logic                  w_tbl_en;
  logic                  w_tbl_we;
  logic [INDEX_BITS-1:0] w_tbl_addr;
  logic [1:0]            w_tbl_wdata;
  logic                  w_ready;
  logic                  w_tbl_lookup;
  logic                  w_rmw_start;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_accept;
  logic                  w_unused_pc;

  assign w_req_idx    = i_req_pc[INDEX_BITS+1:2];
  assign w_fb_idx     = i_fb_pc[INDEX_BITS+1:2];
  assign w_unused_pc  = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                          i_fb_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_fb_pc[1:0]};
  assign w_head_idx   = r_fb_idx[r_rd_ptr];
  assign w_head_taken = r_fb_taken[r_rd_ptr];
  assign w_full       = (r_count == CNT_W'(FB_DEPTH));
  assign w_empty      = (r_count == '0);

  // Saturating counter update for the FIFO head, from last cycle's read
  always_comb begin
    w_upd = i_tbl_rdata;
    if (w_head_taken) begin
      if (i_tbl_rdata != 2'b11) w_upd = i_tbl_rdata + 2'd1;
    end else begin
      if (i_tbl_rdata != 2'b00) w_upd = i_tbl_rdata - 2'd1;
    end
  end

  // Table port arbitration
  always_comb begin
    w_tbl_en     = 1'b0;
    w_tbl_we     = 1'b0;
    w_tbl_addr   = '0;
    w_tbl_wdata  = '0;
    w_ready      = 1'b0;
    w_tbl_lookup = 1'b0;
    w_rmw_start  = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_tbl_en    = 1'b1;
        w_tbl_we    = 1'b1;
        w_tbl_addr  = r_init_idx;
        w_tbl_wdata = INIT_VALUE;
        w_ready     = 1'b1;
      end
      ST_RUN: begin
        if (r_rmw_wr) begin
          // A flush abandons the write half of the RMW
          if (!i_flush) begin
            w_tbl_en    = 1'b1;
            w_tbl_we    = 1'b1;
            w_tbl_addr  = w_head_idx;
            w_tbl_wdata = w_upd;
            w_pop       = 1'b1;
          end
        end else if (w_full) begin
          w_tbl_en    = 1'b1;
          w_tbl_addr  = w_head_idx;
          w_rmw_start = 1'b1;
        end else if (i_req_valid) begin
          w_tbl_en     = 1'b1;
          w_tbl_addr   = w_req_idx;
          w_ready      = 1'b1;
          w_tbl_lookup = 1'b1;
        end else if (!w_empty) begin
          w_tbl_en    = 1'b1;
          w_tbl_addr  = w_head_idx;
          w_rmw_start = 1'b1;
        end else begin
          w_ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_accept = w_ready & i_req_valid;
  assign w_push   = i_fb_valid & ~i_flush & (~w_full | w_pop);

  assign o_tbl_en     = w_tbl_en;
  assign o_tbl_we     = w_tbl_we;
  assign o_tbl_addr   = w_tbl_addr;
  assign o_tbl_wdata  = w_tbl_wdata;
  assign o_req_ready  = w_ready;
  assign o_fb_drop    = i_fb_valid & ~i_flush & w_full & ~w_pop;
  assign o_init_busy  = (r_state != ST_RUN);
  assign o_pred_valid = r_pred_valid;
  assign o_pred       = r_pred_tbl & i_tbl_rdata[1];

  // Feedback FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fb_idx[r_wr_ptr]   <= w_fb_idx;
      r_fb_taken[r_wr_ptr] <= i_fb_outcome;
    end
  end

  // Control state, init sequencer, FIFO pointers, prediction pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_START;
      r_init_idx   <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_rmw_wr     <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_tbl   <= 1'b0;
    end else begin
      r_pred_valid <= w_accept;
      r_pred_tbl   <= w_tbl_lookup & ~i_flush;
      if (i_flush) begin
        r_state    <= ST_START;
        r_init_idx <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_rmw_wr   <= 1'b0;
      end else begin
        case (r_state)
          ST_START: r_state <= ST_INIT;
          ST_INIT: begin
            r_init_idx <= r_init_idx + INDEX_BITS'(1);
            if (r_init_idx == {INDEX_BITS{1'b1}}) r_state <= ST_RUN;
          end
          default: ;
        endcase
        r_rmw_wr <= w_rmw_start;
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

endmodule
